// File: rtl/mutex_rr_scheduler.sv
// mutex_rr_scheduler: five-requester round-robin scheduler for one shared resource.
// A grant lasts until the owner drops req, pulses done, or reaches MAX_HOLD cycles.
// At least one idle cycle separates one owner from the next.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | no owner; grant the first requester found from ptr, cyclically
//   S_GRANT | gnt[gnt_id] is high; watch for release conditions every edge
//   S_GAP   | one forced idle cycle between owners (timeout may pulse here)
module mutex_rr_scheduler #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req,
  input  logic [4:0] done,
  output logic [4:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  logic [1:0]       state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic       pick_vld;
  logic [2:0] pick_id;
  logic [3:0] idx;

  logic rel_req;
  logic rel_done;
  logic rel_to;
  logic rel_any;

  // Cyclic search from ptr; walking backwards lets the nearest hit win last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = 3'd0;
    idx      = 4'd0;
    for (int k = 4; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (req[idx[2:0]]) begin
        pick_vld = 1'b1;
        pick_id  = idx[2:0];
      end
    end
  end

  // Release causes for the current owner; bits of other requesters are ignored.
  always_comb begin
    rel_req  = ~req[gnt_id];
    rel_done = done[gnt_id];
    rel_to   = (MAX_HOLD != 0) && (cnt == HOLD_LIM);
    rel_any  = rel_req | rel_done | rel_to;
  end

  assign busy = |gnt;

  // Scheduler state, grant register, hold counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr     <= 3'd0;
      cnt     <= '0;
      gnt     <= 5'b00000;
      gnt_id  <= 3'd0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt    <= 5'b00001 << pick_id;
            gnt_id <= pick_id;
            cnt    <= CNT_W'(1);
            state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (rel_any) begin
            gnt     <= 5'b00000;
            // timeout is flagged only when the hold limit alone ended the grant
            timeout <= rel_to & ~rel_req & ~rel_done;
            ptr     <= (gnt_id == 3'd4) ? 3'd0 : gnt_id + 3'd1;
            cnt     <= '0;
            state   <= S_GAP;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          gnt   <= 5'b00000;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
